register_updown_counter: RTL and testbench
==========================================

Name: register_updown_counter

Overview:
- Parametrised successor of the 7-bit register increment chain: a clocked register holding a WIDTH-bit value.
- Each cycle the register either holds, loads, increments or decrements its value.
- Drives dual-rail outputs (Out/notOut) so that downstream register-path logic consuming In/notIn pairs connects directly.
- Adds decrement, parallel load, a registered carry/borrow pulse, a terminal-count flag and an optional saturating mode.

Parameters:
- WIDTH, 7, register width in bits (>=2).
- RESET_VALUE, 0, value loaded into Out on reset (WIDTH bits).
- SATURATE, 0, 0 = wrap-around at limits; 1 = clamp at all-ones (up) / zero (down).

Ports:
- CLK  input  1  rising-edge clock.
- nRST  input  1  synchronous active-low reset.
- EN  input  1  count/load enable; 0 forces hold.
- LD  input  1  parallel load request.
- D  input  WIDTH  parallel load data.
- INC  input  1  increment-by-one request.
- DEC  input  1  decrement-by-one request.
- Out  output  WIDTH  registered value.
- notOut  output  WIDTH  registered bitwise complement of Out.
- CO  output  1  registered carry/borrow pulse.
- TC  output  1  registered terminal count.

Behaviour:
- Reset:
  - nRST=0 at a rising CLK edge sets Out=RESET_VALUE, notOut=~RESET_VALUE, CO=0, TC=0.
  - Reset overrides every other input, including mid-load or mid-count.
  - No asynchronous path exists.
- Operation priority, evaluated each rising edge with nRST=1:
  - EN=0: hold; CO<=0; TC keeps its value.
  - EN=1, LD=1: Out<=D; CO<=0; INC/DEC ignored.
  - EN=1, LD=0, INC=1, DEC=1: hold; CO<=0 (requests cancel).
  - EN=1, LD=0, INC=1, DEC=0: increment.
  - EN=1, LD=0, INC=0, DEC=1: decrement.
  - EN=1, LD=0, INC=0, DEC=0: hold; CO<=0.
- Latency: one cycle. The new value is visible on Out/notOut after the edge that accepted the operation.
- Increment:
  - Ripple half-adder chain across WIDTH bits. Carry-in is INC; each stage consumes the registered Out and notOut bits.
  - Top-stage carry-out is the overflow condition.
  - SATURATE=0: Out wraps from all-ones to 0; CO<=1 for exactly the following cycle.
  - SATURATE=1: at all-ones, Out holds all-ones; CO<=1 (overflow attempted).
- Decrement:
  - Borrow chain (complement-increment-complement or equivalent).
  - SATURATE=0: Out wraps from 0 to all-ones; CO<=1 for the following cycle.
  - SATURATE=1: at 0, Out holds 0; CO<=1.
- CO:
  - High for exactly one cycle per overflow/underflow event. Consecutive events give CO high on consecutive cycles.
  - Never set by load or hold.
- TC: registered, equal to (next Out == all-ones) when the direction of the last accepted INC/DEC was up, or (next Out == 0) when it was down. The direction flag is internal, reset to up, and updated only on an accepted increment or decrement.
- notOut: always exactly ~Out, registered in the same flop stage. Not derived combinationally from Out.
- Width rules:
  - D is taken at full WIDTH.
  - RESET_VALUE is truncated to WIDTH.
  - No carry is visible outside except CO.

Test Plan:
- Reset: WIDTH=7, RESET_VALUE=7'h05; hold nRST=0 for 2 cycles with INC=1, EN=1 -> Out=0x05, notOut=0x7A, CO=0, TC=0. Release nRST -> Out=0x06 one cycle later.
- Wrap-up: SATURATE=0; load D=0x7E, then INC for 3 cycles -> Out 0x7F (TC=1), 0x00 (CO=1 that cycle only), 0x01 (CO=0, TC=0).
- Wrap-down: SATURATE=0; load 0x01, then DEC for 3 cycles -> Out 0x00 (TC=1), 0x7F (CO=1), 0x7E. notOut equals ~Out every cycle.
- Saturate: SATURATE=1; load 0x7F, INC for 2 cycles -> Out stays 0x7F, CO=1 both cycles. Load 0x00, DEC -> Out stays 0x00, CO=1.
- Priority/cancel: Out=0x10:
  - LD=1, D=0x33, INC=1 -> Out=0x33.
  - INC=DEC=1 -> Out=0x33, CO=0.
  - EN=0, INC=1 -> Out=0x33.
- Reset mid-count: counting up from 0x7D; assert nRST=0 on the cycle INC would wrap -> Out=RESET_VALUE, CO=0. Direction flag returns to up.

Source files
------------

// File: rtl/register_updown_counter_if.sv
// Bus bundle for the up/down counter: control and load data in, dual-rail
// value plus the carry and terminal-count flags out.
interface register_updown_counter_if #(
    parameter int WIDTH = 7
);
    logic             EN;
    logic             LD;
    logic [WIDTH-1:0] D;
    logic             INC;
    logic             DEC;
    logic [WIDTH-1:0] Out;
    logic [WIDTH-1:0] notOut;
    logic             CO;
    logic             TC;

    modport master (
        output EN, LD, D, INC, DEC,
        input  Out, notOut, CO, TC
    );

    modport slave (
        input  EN, LD, D, INC, DEC,
        output Out, notOut, CO, TC
    );
endinterface

// File: rtl/register_updown_counter.sv
// WIDTH-bit register that holds, loads, increments or decrements each cycle,
// with dual-rail outputs, a one-cycle carry/borrow pulse and terminal count.
module register_updown_counter #(
    parameter int               WIDTH       = 7,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit               SATURATE    = 1'b0
) (
    input  logic                     CLK,
    input  logic                     nRST,
    register_updown_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ALL_ZERO = '0;

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] not_out_q, not_out_d;
    logic             co_q, co_d;
    logic             tc_q, tc_d;
    logic             dir_up_q, dir_up_d;

    logic [WIDTH:0]   carry;
    logic [WIDTH:0]   borrow;
    logic [WIDTH-1:0] inc_val;
    logic [WIDTH-1:0] dec_val;

    // Half-adder ripple for increment; the borrow ripple propagates through
    // the registered complement rail, so notOut feeds the decrement path.
    always_comb begin
        carry    = '0;
        borrow   = '0;
        inc_val  = '0;
        dec_val  = '0;
        carry[0]  = bus.INC;
        borrow[0] = bus.DEC;
        for (int i = 0; i < WIDTH; i++) begin
            inc_val[i]  = out_q[i] ^ carry[i];
            carry[i+1]  = out_q[i] & carry[i];
            dec_val[i]  = out_q[i] ^ borrow[i];
            borrow[i+1] = not_out_q[i] & borrow[i];
        end
    end

    always_comb begin
        out_d    = out_q;
        co_d     = 1'b0;
        dir_up_d = dir_up_q;
        tc_d     = tc_q;
        if (bus.EN) begin
            if (bus.LD) begin
                out_d = bus.D;
            end else if (bus.INC && !bus.DEC) begin
                dir_up_d = 1'b1;
                co_d     = carry[WIDTH];
                out_d    = (SATURATE && carry[WIDTH]) ? ALL_ONES : inc_val;
            end else if (bus.DEC && !bus.INC) begin
                dir_up_d = 1'b0;
                co_d     = borrow[WIDTH];
                out_d    = (SATURATE && borrow[WIDTH]) ? ALL_ZERO : dec_val;
            end
            tc_d = dir_up_d ? (out_d == ALL_ONES) : (out_d == ALL_ZERO);
        end
        not_out_d = ~out_d;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            out_q     <= RESET_VALUE;
            not_out_q <= ~RESET_VALUE;
            co_q      <= 1'b0;
            tc_q      <= 1'b0;
            dir_up_q  <= 1'b1;
        end else begin
            out_q     <= out_d;
            not_out_q <= not_out_d;
            co_q      <= co_d;
            tc_q      <= tc_d;
            dir_up_q  <= dir_up_d;
        end
    end

    assign bus.Out    = out_q;
    assign bus.notOut = not_out_q;
    assign bus.CO     = co_q;
    assign bus.TC     = tc_q;

endmodule

// File: tb/tb_register_updown_counter.sv
// Directed plus short random stimulus on a wrapping and a saturating counter,
// checked against a behavioural model through per-instance scoreboards.
module tb_register_updown_counter;

    typedef struct packed {
        logic [6:0] out;
        logic       co;
        logic       tc;
    } exp_t;

    logic CLK;
    logic nRST;
    int   errors;
    int   checks;

    exp_t q_w[$];
    exp_t q_s[$];

    logic [6:0] m_out [2];
    bit         m_dir [2];
    bit         m_co  [2];
    bit         m_tc  [2];

    register_updown_counter_if #(.WIDTH(7)) bw ();
    register_updown_counter_if #(.WIDTH(7)) bs ();

    register_updown_counter #(.WIDTH(7), .RESET_VALUE(7'h05), .SATURATE(1'b0)) dut_wrap (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bw)
    );

    register_updown_counter #(.WIDTH(7), .RESET_VALUE(7'h05), .SATURATE(1'b1)) dut_sat (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bs)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic model_upd(input int k, input bit sat, input bit nrst, input bit en,
                             input bit ld, input logic [6:0] d, input bit inc, input bit dec);
        if (!nrst) begin
            m_out[k] = 7'h05;
            m_co[k]  = 1'b0;
            m_tc[k]  = 1'b0;
            m_dir[k] = 1'b1;
        end else if (!en) begin
            m_co[k] = 1'b0;
        end else begin
            m_co[k] = 1'b0;
            if (ld) begin
                m_out[k] = d;
            end else if (inc && !dec) begin
                m_dir[k] = 1'b1;
                if (m_out[k] == 7'h7F) begin
                    m_co[k]  = 1'b1;
                    m_out[k] = sat ? 7'h7F : 7'h00;
                end else begin
                    m_out[k] = m_out[k] + 7'd1;
                end
            end else if (dec && !inc) begin
                m_dir[k] = 1'b0;
                if (m_out[k] == 7'h00) begin
                    m_co[k]  = 1'b1;
                    m_out[k] = sat ? 7'h00 : 7'h7F;
                end else begin
                    m_out[k] = m_out[k] - 7'd1;
                end
            end
            m_tc[k] = m_dir[k] ? (m_out[k] == 7'h7F) : (m_out[k] == 7'h00);
        end
    endtask

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input string name, input logic [6:0] o, input logic [6:0] no,
                             input logic co, input logic tc, input bit have, input exp_t e);
        checks++;
        assert (have) else begin
            errors++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", name);
        end
        if (have) begin
            check({name, "_out"},    o,            e.out);
            check({name, "_notout"}, no,           ~e.out);
            check({name, "_co"},     {6'd0, co},   {6'd0, e.co});
            check({name, "_tc"},     {6'd0, tc},   {6'd0, e.tc});
        end
    endtask

    task automatic step(input bit nrst, input bit en, input bit ld, input logic [6:0] d,
                        input bit inc, input bit dec);
        exp_t e;
        bit   have;
        @(negedge CLK);
        nRST = nrst;
        bw.EN = en; bw.LD = ld; bw.D = d; bw.INC = inc; bw.DEC = dec;
        bs.EN = en; bs.LD = ld; bs.D = d; bs.INC = inc; bs.DEC = dec;
        for (int k = 0; k < 2; k++) begin
            model_upd(k, (k == 1), nrst, en, ld, d, inc, dec);
            e = '{out: m_out[k], co: m_co[k], tc: m_tc[k]};
            if (k == 0) q_w.push_back(e);
            else        q_s.push_back(e);
        end
        @(posedge CLK);
        #1;
        have = (q_w.size() > 0);
        e = have ? q_w.pop_front() : '0;
        check_dut("wrap", bw.Out, bw.notOut, bw.CO, bw.TC, have, e);
        have = (q_s.size() > 0);
        e = have ? q_s.pop_front() : '0;
        check_dut("sat", bs.Out, bs.notOut, bs.CO, bs.TC, have, e);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        nRST = 1'b0;
        bw.EN = 1'b0; bw.LD = 1'b0; bw.D = '0; bw.INC = 1'b0; bw.DEC = 1'b0;
        bs.EN = 1'b0; bs.LD = 1'b0; bs.D = '0; bs.INC = 1'b0; bs.DEC = 1'b0;

        // reset held two cycles while counting is requested
        step(0, 1, 0, 7'h00, 1, 0);
        step(0, 1, 0, 7'h00, 1, 0);
        step(1, 1, 0, 7'h00, 1, 0);

        // wrap / saturate upward
        step(1, 1, 1, 7'h7E, 0, 0);
        step(1, 1, 0, 7'h00, 1, 0);
        step(1, 1, 0, 7'h00, 1, 0);
        step(1, 1, 0, 7'h00, 1, 0);

        // wrap / saturate downward
        step(1, 1, 1, 7'h01, 0, 0);
        step(1, 1, 0, 7'h00, 0, 1);
        step(1, 1, 0, 7'h00, 0, 1);
        step(1, 1, 0, 7'h00, 0, 1);

        // priority and cancel
        step(1, 1, 1, 7'h10, 0, 0);
        step(1, 1, 1, 7'h33, 1, 0);
        step(1, 1, 0, 7'h00, 1, 1);
        step(1, 0, 0, 7'h00, 1, 0);
        step(1, 0, 1, 7'h55, 0, 1);
        step(1, 1, 0, 7'h00, 0, 0);

        // TC kept through EN=0 while set
        step(1, 1, 1, 7'h7E, 0, 0);
        step(1, 1, 0, 7'h00, 1, 0);
        step(1, 0, 0, 7'h00, 1, 0);

        // reset mid-count on the wrapping edge
        step(1, 1, 1, 7'h7D, 0, 0);
        step(1, 1, 0, 7'h00, 1, 0);
        step(1, 1, 0, 7'h00, 1, 0);
        step(0, 1, 0, 7'h00, 1, 0);
        step(1, 1, 0, 7'h00, 1, 0);

        // direction returns to up after reset
        step(1, 1, 0, 7'h00, 0, 1);
        step(0, 1, 0, 7'h00, 0, 0);
        step(1, 1, 1, 7'h7F, 0, 0);
        step(1, 1, 1, 7'h00, 0, 0);

        for (int n = 0; n < 60; n++) begin
            step(($urandom_range(0, 19) != 0), ($urandom_range(0, 5) != 0),
                 ($urandom_range(0, 7) == 0), 7'($urandom_range(0, 127)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
